decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage.sv | 110 +++++++++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: upstream/downstream handshake and decoded bundle.
// slave = decode stage side, master = producer/consumer side.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, opcode, rd, funct3,
    output rs1, rs2, funct7, imm, fmt, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rd, funct3,
    input  rs1, rs2, funct7, imm, fmt, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: one registered slot decoding RV32 words into fields,
// format code and sign-extended immediate. Ports: clk, reset, io (slave).
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave io
);
  logic [31:0]     ins;
  logic [6:0]      op;
  logic [2:0]      d_fmt;
  logic            d_ill;
  logic [31:0]     d_imm32;
  logic [XLEN-1:0] d_imm;
  logic            xfer;

  logic            valid_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      fmt_q;
  logic            ill_q;

  assign ins = io.in_instr;
  assign op  = ins[6:0];

  always_comb begin
    d_fmt   = 3'd7;
    d_imm32 = '0;
    unique case (1'b1)
      op == 7'b0110011: d_fmt = 3'd0;
      op == 7'b0010011,
      op == 7'b0000011,
      op == 7'b1100111,
      op == 7'b1110011: begin
        d_fmt   = 3'd1;
        d_imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      op == 7'b0100011: begin
        d_fmt   = 3'd2;
        d_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      op == 7'b1100011: begin
        d_fmt   = 3'd3;
        d_imm32 = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
      end
      op == 7'b0110111,
      op == 7'b0010111: begin
        d_fmt   = 3'd4;
        d_imm32 = {ins[31:12], 12'b0};
      end
      op == 7'b1101111: begin
        d_fmt   = 3'd5;
        d_imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};
      end
      default: d_fmt = 3'd7;
    endcase
    // every supported opcode ends in 2'b11, but keep the check explicit
    if (ins[1:0] != 2'b11) begin
      d_fmt   = 3'd7;
      d_imm32 = '0;
    end
  end

  assign d_ill = (d_fmt == 3'd7);
  // bit 31 of the 32-bit immediate is always instr[31] (or 0 when
  // illegal/R), so a signed widen gives the XLEN sign extension
  assign d_imm = XLEN'($signed(d_imm32));

  assign io.in_ready = (!valid_q | io.out_ready) & !io.flush;
  assign xfer        = io.in_valid & io.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      fmt_q   <= '0;
      ill_q   <= 1'b0;
    end else if (io.flush) begin
      valid_q <= 1'b0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      pc_q    <= io.in_pc;
      instr_q <= ins;
      imm_q   <= d_imm;
      fmt_q   <= d_fmt;
      ill_q   <= d_ill;
    end else if (io.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign io.out_valid = valid_q;
  assign io.out_pc    = pc_q;
  assign io.opcode    = instr_q[6:0];
  assign io.rd        = instr_q[11:7];
  assign io.funct3    = instr_q[14:12];
  assign io.rs1       = instr_q[19:15];
  assign io.rs2       = instr_q[24:20];
  assign io.funct7    = instr_q[31:25];
  assign io.imm       = imm_q;
  assign io.fmt       = fmt_q;
  assign io.illegal   = ill_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors, queue scoreboard and monitor.
// Drives a 32-bit and a 64-bit XLEN instance in lockstep.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();
  decode_stage_if #(.XLEN(64), .PC_W(32)) bus64 ();

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );
  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .reset(reset), .io(bus64)
  );

  assign bus64.in_valid  = bus.in_valid;
  assign bus64.in_instr  = bus.in_instr;
  assign bus64.in_pc     = bus.in_pc;
  assign bus64.flush     = bus.flush;
  assign bus64.out_ready = bus.out_ready;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
    input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [6:0] f7, input logic [63:0] imm, input logic [2:0] fmt,
    input logic ill);
    exp_t e;
    e.pc = pc; e.op = op; e.rd = rd; e.f3 = f3; e.rs1 = rs1;
    e.rs2 = rs2; e.f7 = f7; e.imm = imm; e.fmt = fmt; e.ill = ill;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out pc=%h exp=none", bus.out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc", 64'(bus.out_pc), 64'(e.pc));
        chk("opcode", 64'(bus.opcode), 64'(e.op));
        chk("rd", 64'(bus.rd), 64'(e.rd));
        chk("funct3", 64'(bus.funct3), 64'(e.f3));
        chk("rs1", 64'(bus.rs1), 64'(e.rs1));
        chk("rs2", 64'(bus.rs2), 64'(e.rs2));
        chk("funct7", 64'(bus.funct7), 64'(e.f7));
        chk("imm32", 64'(bus.imm), {32'b0, e.imm[31:0]});
        chk("fmt", 64'(bus.fmt), 64'(e.fmt));
        chk("illegal", 64'(bus.illegal), 64'(e.ill));
        chk("valid64", 64'(bus64.out_valid), 64'd1);
        chk("imm64", bus64.imm, e.imm);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = e.pc;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) q.push_back(e);
    else begin
      total_cnt++;
      $display("FAIL send_timeout got=stalled exp=accept pc=%h", e.pc);
    end
    bus.in_valid = 1'b0;
  endtask

  exp_t e_addi, e_sw, e_beq, e_lui, e_lui2, e_jal, e_add, e_bad;
  exp_t e_c, e_7f;

  initial begin
    e_addi = mk(32'h100, 7'h13, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    e_sw   = mk(32'h104, 7'h23, 5'd8, 3'd2, 5'd2, 5'd5, 7'h00,
                64'h8, 3'd2, 1'b0);
    e_beq  = mk(32'h108, 7'h63, 5'd29, 3'd0, 5'd0, 5'd0, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    e_lui  = mk(32'h10C, 7'h37, 5'd5, 3'd5, 5'd8, 5'd3, 7'h09,
                64'h0000_0000_1234_5000, 3'd4, 1'b0);
    e_lui2 = mk(32'h110, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h40,
                64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    e_jal  = mk(32'h114, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd8, 7'h00,
                64'h8, 3'd5, 1'b0);
    e_add  = mk(32'h118, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00,
                64'h0, 3'd0, 1'b0);
    e_bad  = mk(32'h11C, 7'h10, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F,
                64'h0, 3'd7, 1'b1);
    e_c    = mk(32'h200, 7'h13, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    e_7f   = mk(32'h300, 7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00,
                64'h0, 3'd7, 1'b1);

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_fields", 64'({bus.opcode, bus.rd, bus.funct3, bus.rs1,
        bus.rs2, bus.funct7}), 64'd0);
    chk("rst_imm", 64'(bus.imm), 64'd0);
    chk("rst_fmt", 64'(bus.fmt), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // back-to-back stream with out_ready=1
    send(32'hFFF10093, e_addi);
    send(32'h00512423, e_sw);
    send(32'hFE000EE3, e_beq);
    send(32'h123452B7, e_lui);
    send(32'h800002B7, e_lui2);
    send(32'h008000EF, e_jal);
    send(32'h002081B3, e_add);
    send(32'hFFF10090, e_bad);
    @(negedge clk);
    @(negedge clk);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // backpressure: hold addi for 3 cycles, then drain+refill
    bus.out_ready = 1'b0;
    send(32'hFFF10093, e_addi);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00512423;
    bus.in_pc = e_sw.pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_pc", 64'(bus.out_pc), 64'h100);
      chk("bp_imm", 64'(bus.imm), 64'hFFFF_FFFF);
      chk("bp_rd", 64'(bus.rd), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    q.push_back(e_sw);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;

    // flush while held, with an incoming word
    bus.out_ready = 1'b0;
    send(32'hFFF10093, e_c);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h008000EF;
    bus.in_pc = 32'h204;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    q.delete();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_pc_not_new", 64'(bus.out_pc == 32'h204), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h0000007F, e_7f);
    @(negedge clk);
    @(posedge clk);
    #1;

    // reset beats a held bundle and a pending transfer
    bus.out_ready = 1'b0;
    send(32'h123452B7, e_lui);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFE000EE3;
    @(posedge clk);
    #1;
    q.delete();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_pc", 64'(bus.out_pc), 64'd0);
    chk("rst2_imm", 64'(bus.imm), 64'd0);
    chk("rst2_fmt", 64'(bus.fmt), 64'd0);
    chk("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
